// File: rtl/cw341_usb_fifo_reg.sv
// USB register slave for a 32-bit capture FIFO drained byte-by-byte, plus status/control registers.
// Single clock domain; the head word is held in a register so the next word is visible without a bubble.
module cw341_usb_fifo_reg #(
    parameter int          pBYTECNT_SIZE = 7,
    parameter int          pAW           = 9,
    parameter logic [7:0]  pADDR_DATA    = 8'h20,
    parameter logic [7:0]  pADDR_STATUS  = 8'h21,
    parameter logic [7:0]  pADDR_CTRL    = 8'h22
) (
    input  logic                     clk_usb,
    input  logic                     reset,
    input  logic [7:0]               reg_address,
    input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    input  logic [7:0]               reg_datao,
    input  logic                     reg_read,
    input  logic                     reg_write,
    output logic [7:0]               reg_datai,
    output logic                     fast_fifo_read,
    input  logic                     fifo_wr_en,
    input  logic [31:0]              fifo_wr_data,
    output logic                     fifo_empty,
    output logic                     fifo_full
);

    localparam int             DEPTH    = 1 << pAW;
    localparam logic [pAW:0]   FULL_CNT = (pAW + 1)'(DEPTH);

    logic [31:0]    mem [DEPTH];
    logic [pAW-1:0] wr_ptr;
    logic [pAW-1:0] rd_ptr;
    logic [pAW-1:0] rd_ptr_next;
    logic [pAW:0]   count;
    logic [15:0]    count16;
    logic [31:0]    head;
    logic [7:0]     ctrl;
    logic           overflow;
    logic           underflow;
    logic           read_q;
    logic [7:0]     rd_mux;

    logic full, empty, sel_data, ctrl_wr, flush, clr_flags;
    logic pop_req, pop_ok, push_ok, ovf_evt, udf_evt;

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign fifo_full   = full;
    assign fifo_empty  = empty;
    assign count16     = 16'(count);
    assign rd_ptr_next = rd_ptr + 1'b1;

    assign sel_data  = (reg_address == pADDR_DATA);
    assign ctrl_wr   = reg_write && (reg_address == pADDR_CTRL) && (reg_bytecnt == '0);
    assign flush     = ctrl_wr && reg_datao[0];
    assign clr_flags = ctrl_wr && reg_datao[2];

    // The word is consumed when the host finishes reading lane 3, seen as read strobe falling.
    assign pop_req = read_q && !reg_read && sel_data && (reg_bytecnt[1:0] == 2'd3);
    assign pop_ok  = pop_req && !empty && !flush;
    assign push_ok = fifo_wr_en && !flush && (!full || pop_ok);
    assign ovf_evt = fifo_wr_en && !flush && full && !pop_ok;
    assign udf_evt = pop_req && empty;

    always_ff @(posedge clk_usb) begin
        if (push_ok) begin
            mem[wr_ptr] <= fifo_wr_data;
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (reg_address)
            pADDR_DATA: begin
                if (empty) begin
                    rd_mux = 8'hEE;
                end else begin
                    case (reg_bytecnt[1:0])
                        2'd0:    rd_mux = head[7:0];
                        2'd1:    rd_mux = head[15:8];
                        2'd2:    rd_mux = head[23:16];
                        default: rd_mux = head[31:24];
                    endcase
                end
            end
            pADDR_STATUS: begin
                if (reg_bytecnt == pBYTECNT_SIZE'(0)) begin
                    rd_mux = count16[7:0];
                end else if (reg_bytecnt == pBYTECNT_SIZE'(1)) begin
                    rd_mux = count16[15:8];
                end else if (reg_bytecnt == pBYTECNT_SIZE'(2)) begin
                    rd_mux = {4'b0000, overflow, underflow, full, empty};
                end
            end
            pADDR_CTRL: rd_mux = ctrl;
            default:    rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            head           <= '0;
            ctrl           <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            read_q         <= 1'b0;
            reg_datai      <= 8'h00;
            fast_fifo_read <= 1'b0;
        end else begin
            read_q         <= reg_read;
            reg_datai      <= rd_mux;
            fast_fifo_read <= ctrl[1] && sel_data;

            if (ctrl_wr) begin
                ctrl <= {reg_datao[7:3], 1'b0, reg_datao[1], 1'b0};
            end

            // A new event in the same cycle as a clear keeps the flag set.
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end else if (clr_flags) begin
                underflow <= 1'b0;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr <= rd_ptr_next;
                end
                if (push_ok && !pop_ok) begin
                    count <= count + 1'b1;
                end else if (pop_ok && !push_ok) begin
                    count <= count - 1'b1;
                end

                // Refill the head: from storage if more words remain, else straight from the push bus.
                if (pop_ok) begin
                    if (count > (pAW + 1)'(1)) begin
                        head <= mem[rd_ptr_next];
                    end else if (push_ok) begin
                        head <= fifo_wr_data;
                    end
                end else if (push_ok && empty) begin
                    head <= fifo_wr_data;
                end
            end
        end
    end

endmodule
